// File: rtl/data_memory_arbiter.sv
// Multi-channel word memory: CHANNELS request/ack ports share one array through an ARB -> MEM -> ACK sequencer.
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration; default build is round-robin.
module data_memory_arbiter #(
  parameter int BUS      = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     req,
  input  logic [CHANNELS-1:0]     we,
  input  logic [CHANNELS*BUS-1:0] addr,
  input  logic [CHANNELS*BUS-1:0] wdata,
  output logic [CHANNELS*BUS-1:0] rdata,
  output logic [CHANNELS-1:0]     ack,
  output logic [CHANNELS-1:0]     addr_err,
  output logic                    busy,
  output logic [1:0]              dbg_state
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Handshake: a requester raises req with we/addr/wdata and holds them until its one-cycle
  // ack pulse; req still high in the cycle after ack counts as a fresh access.
  typedef enum logic [1:0] {ARB = 2'd0, MEM = 2'd1, ACK = 2'd2} state_t;

  state_t          r_state, w_next;
  logic [CHW-1:0]  r_ch;
  logic [ADDRW-1:0] r_idx;
  logic            r_we, r_oor;
  logic [BUS-1:0]  r_wdata;
  logic [CHANNELS-1:0]     r_ack, r_err;
  logic [CHANNELS*BUS-1:0] r_rdata;
  logic            r_busy;
  logic [BUS-1:0]  r_mem [DEPTH];

  logic            w_found;
  logic [CHW-1:0]  w_win;
  logic [BUS-1:0]  w_sel_addr;
  logic [ADDRW-1:0] w_idx;
  logic            w_oor;
  logic [BUS-1:0]  w_rd;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_found = 1'b1;
        w_win   = CHW'(i);
      end
    end
  end
`else
  logic [CHW-1:0] r_ptr;

  function automatic logic [CHW-1:0] rr_cand(input logic [CHW-1:0] ptr, input int k);
    rr_cand = CHW'((int'(ptr) + k) % CHANNELS);
  endfunction

  // Search starts one past the last grant so every requester is reached within CHANNELS grants.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!w_found && req[rr_cand(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_cand(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ptr <= CHW'(CHANNELS - 1);
    else if (r_state == ARB && w_found) r_ptr <= w_win;
  end
`endif

  // Range check uses the whole word address so high address bits cannot alias into the array.
  assign w_sel_addr = addr[int'(w_win)*BUS +: BUS];
  assign w_idx      = w_sel_addr[ADDRW+1:2];
  assign w_oor      = (w_sel_addr >> 2) >= BUS'(DEPTH);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB:     if (w_found) w_next = MEM;
      MEM:     w_next = ACK;
      ACK:     w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB;
      r_ch    <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_wdata <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ARB);
      r_ack   <= '0;
      if (r_state == ARB && w_found) begin
        r_ch    <= w_win;
        r_idx   <= w_idx;
        r_we    <= we[w_win];
        r_oor   <= w_oor;
        r_wdata <= wdata[int'(w_win)*BUS +: BUS];
      end
      if (r_state == MEM) begin
        r_ack[r_ch] <= 1'b1;
        if (!r_we) r_rdata[int'(r_ch)*BUS +: BUS] <= w_rd;
        if (r_oor) r_err[r_ch] <= 1'b1;
      end
    end
  end

  // Array is never reset; a write still pending when reset falls is dropped.
  always_ff @(posedge clk) begin
    if (reset && r_state == MEM && r_we && !r_oor) r_mem[r_idx] <= r_wdata;
  end

  assign w_rd = r_oor ? '0 : r_mem[r_idx];

  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign addr_err  = r_err;
  assign busy      = r_busy;
  assign dbg_state = r_state;
endmodule
